fifo_spi_reader: RTL and testbench

FIFO_SPI_READER -- requirements
Module: fifo_spi_reader

---
 rtl/fifo_spi_reader_if.sv | 25 ++
 rtl/fifo_spi_reader.sv | 199 +++++++++++++++++++
 tb/tb_fifo_spi_reader.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_spi_reader_if.sv
// SPI pin bundle plus count-FIFO read port and command status for fifo_spi_reader.
// slave = the reader block, master = host/FIFO side.
interface fifo_spi_reader_if;
    logic        spi_sclk;
    logic        spi_cs_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic [23:0] fifo_data;
    logic        fifo_empty;
    logic [3:0]  fifo_level;
    logic        fifo_rd_en;
    logic [3:0]  spi_cmd;
    logic        cmd_valid;
    logic        busy;

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, fifo_data, fifo_empty, fifo_level,
        output spi_miso, fifo_rd_en, spi_cmd, cmd_valid, busy
    );

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, fifo_data, fifo_empty, fifo_level,
        input  spi_miso, fifo_rd_en, spi_cmd, cmd_valid, busy
    );
endinterface

// File: rtl/fifo_spi_reader.sv
// SPI mode-0 slave: READ_COUNT (0x1) pops one 24-bit FIFO word, READ_LEVEL (0x2) returns a status byte.
// Optional macro FIFO_SPI_STATUS_HEADER_EN prefixes READ_COUNT frames with that status byte.
module fifo_spi_reader (
    input  logic             clk,
    input  logic             reset,
    fifo_spi_reader_if.slave bus
);
`ifdef FIFO_SPI_STATUS_HEADER_EN
    localparam int SR_W = 32;
`else
    localparam int SR_W = 24;
`endif
    localparam logic [5:0] COUNT_BITS    = 6'(SR_W);
    localparam logic [5:0] LEVEL_BITS    = 6'd8;
    localparam logic [3:0] OP_READ_COUNT = 4'h1;
    localparam logic [3:0] OP_READ_LEVEL = 4'h2;
    // Idle values of the synchronised inputs, ordered {mosi, cs_n, sclk}.
    localparam logic [2:0] SYNC_IDLE     = 3'b010;

    typedef enum logic [2:0] {IDLE, CMD, FETCH, SHIFT, DONE} state_t;

    logic [2:0]      raw_in;
    logic [2:0]      sync_s;
    logic            sclk_s, cs_n_s, mosi_s;
    logic            sclk_prev_reg, cs_n_prev_reg;
    logic            sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [7:0]      status;

    state_t          state_reg;
    logic [SR_W-1:0] sr_reg;
    logic [6:0]      cmd_sr_reg;
    logic [5:0]      bit_cnt_reg;
    logic [5:0]      frame_len_reg;
    logic            level_frame_reg;
    logic            fetch_phase_reg;
    logic            fetch_empty_reg;
    logic            underflow_reg;
    logic            miso_reg;
    logic            rd_en_reg;
    logic [3:0]      cmd_reg;
    logic            cmd_valid_reg;
    logic            busy_reg;
    logic [1:0]      settle_reg;
    logic            armed_reg;
`ifdef FIFO_SPI_STATUS_HEADER_EN
    logic [7:0]      hdr_reg;
`endif

    assign raw_in = {bus.spi_mosi, bus.spi_cs_n, bus.spi_sclk};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic s1_reg, s2_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    s1_reg <= SYNC_IDLE[gi];
                    s2_reg <= SYNC_IDLE[gi];
                end else begin
                    s1_reg <= raw_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign sync_s[gi] = s2_reg;
        end
    endgenerate

    assign sclk_s = sync_s[0];
    assign cs_n_s = sync_s[1];
    assign mosi_s = sync_s[2];

    // sclk edges only count while the host holds chip select.
    assign sclk_rise = ~cs_n_s & sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~cs_n_s & ~sclk_s & sclk_prev_reg;
    assign cs_fall   = ~cs_n_s & cs_n_prev_reg;
    assign cs_rise   = cs_n_s & ~cs_n_prev_reg;
    assign status    = {bus.fifo_empty, underflow_reg, 2'b00, bus.fifo_level};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            sr_reg          <= '0;
            cmd_sr_reg      <= '0;
            bit_cnt_reg     <= '0;
            frame_len_reg   <= '0;
            level_frame_reg <= 1'b0;
            fetch_phase_reg <= 1'b0;
            fetch_empty_reg <= 1'b0;
            underflow_reg   <= 1'b0;
            miso_reg        <= 1'b0;
            rd_en_reg       <= 1'b0;
            cmd_reg         <= 4'h0;
            cmd_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            sclk_prev_reg   <= 1'b0;
            cs_n_prev_reg   <= 1'b1;
            settle_reg      <= 2'd0;
            armed_reg       <= 1'b0;
`ifdef FIFO_SPI_STATUS_HEADER_EN
            hdr_reg         <= 8'h00;
`endif
        end else begin
            sclk_prev_reg <= sclk_s;
            cs_n_prev_reg <= cs_n_s;
            busy_reg      <= ~cs_n_s;
            cmd_valid_reg <= 1'b0;
            rd_en_reg     <= 1'b0;
            // After reset, a frame may only start once cs_n has been seen high.
            if (settle_reg != 2'd3) settle_reg <= settle_reg + 2'd1;
            else if (cs_n_s)        armed_reg  <= 1'b1;

            if (cs_rise) begin
                state_reg <= IDLE;
                miso_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cs_fall && armed_reg) begin
                            state_reg   <= CMD;
                            bit_cnt_reg <= '0;
                        end
                    end
                    CMD: begin
                        if (sclk_rise) begin
                            cmd_sr_reg  <= {cmd_sr_reg[5:0], mosi_s};
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            if (bit_cnt_reg == 6'd7) begin
                                cmd_reg       <= cmd_sr_reg[6:3];
                                cmd_valid_reg <= 1'b1;
                                bit_cnt_reg   <= '0;
                                case (cmd_sr_reg[6:3])
                                    OP_READ_COUNT: begin
                                        state_reg       <= FETCH;
                                        fetch_phase_reg <= 1'b0;
                                        fetch_empty_reg <= bus.fifo_empty;
`ifdef FIFO_SPI_STATUS_HEADER_EN
                                        hdr_reg         <= status;
`endif
                                        if (bus.fifo_empty) underflow_reg <= 1'b1;
                                        else                rd_en_reg     <= 1'b1;
                                    end
                                    OP_READ_LEVEL: begin
                                        state_reg       <= SHIFT;
                                        sr_reg          <= {status, {(SR_W-8){1'b0}}};
                                        frame_len_reg   <= LEVEL_BITS;
                                        level_frame_reg <= 1'b1;
                                    end
                                    default: state_reg <= DONE;
                                endcase
                            end
                        end
                    end
                    FETCH: begin
                        // Phase 0 lets the popped word appear on fifo_data; phase 1 captures it.
                        if (!fetch_phase_reg) begin
                            fetch_phase_reg <= 1'b1;
                        end else begin
`ifdef FIFO_SPI_STATUS_HEADER_EN
                            sr_reg <= {hdr_reg, fetch_empty_reg ? 24'h000000 : bus.fifo_data};
`else
                            sr_reg <= fetch_empty_reg ? 24'h000000 : bus.fifo_data;
`endif
                            frame_len_reg   <= COUNT_BITS;
                            level_frame_reg <= 1'b0;
                            bit_cnt_reg     <= '0;
                            state_reg       <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (sclk_fall) begin
                            miso_reg <= sr_reg[SR_W-1];
                            sr_reg   <= {sr_reg[SR_W-2:0], 1'b0};
                        end else if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 6'd1;
                            // The host has just sampled the final bit.
                            if (bit_cnt_reg + 6'd1 == frame_len_reg) begin
                                state_reg <= DONE;
                                miso_reg  <= 1'b0;
                                if (level_frame_reg) underflow_reg <= 1'b0;
                            end
                        end
                    end
                    DONE: begin
                        miso_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        miso_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.spi_miso   = miso_reg;
    assign bus.fifo_rd_en = rd_en_reg;
    assign bus.spi_cmd    = cmd_reg;
    assign bus.cmd_valid  = cmd_valid_reg;
    assign bus.busy       = busy_reg;
endmodule

// File: tb/tb_fifo_spi_reader.sv
// Self-checking bench for fifo_spi_reader: SPI host tasks, a FIFO model and a frame-level reference model.
// Honours FIFO_SPI_STATUS_HEADER_EN for the READ_COUNT frame length.
module tb_fifo_spi_reader;
`ifdef FIFO_SPI_STATUS_HEADER_EN
    localparam int FRAME = 32;
`else
    localparam int FRAME = 24;
`endif
    localparam int HALF = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fifo_spi_reader_if bus ();
    fifo_spi_reader dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;

    // Count FIFO: registered read, data valid the clock after fifo_rd_en.
    logic [23:0] mem [0:15];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign bus.fifo_empty = (wr_ptr == rd_ptr);
    assign bus.fifo_level = 4'(wr_ptr - rd_ptr);
    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            bus.fifo_data <= mem[rd_ptr % 16];
            rd_ptr <= rd_ptr + 1;
        end
    end

    int pop_cycles = 0;
    int cv_cycles = 0;
    always @(negedge clk) begin
        if (bus.fifo_rd_en) pop_cycles++;
        if (bus.cmd_valid)  cv_cycles++;
    end

    // Reference model state.
    logic       m_uf = 1'b0;
    logic [3:0] m_cmd = 4'h0;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [23:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr++;
    endtask

    task automatic sclk_bit(input logic b, output logic s);
        bus.spi_mosi = b;
        wait_clk(HALF);
        s = bus.spi_miso;
        bus.spi_sclk = 1'b1;
        wait_clk(HALF);
        bus.spi_sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input int ncmd, input int nbits,
                             output logic [63:0] rx, output logic busy_mid);
        logic s;
        rx = '0;
        bus.spi_cs_n = 1'b0;
        wait_clk(HALF);
        busy_mid = bus.busy;
        for (int i = 0; i < ncmd; i++) sclk_bit(cmd[7-i], s);
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(1'b0, s);
            rx = {rx[62:0], s};
        end
        wait_clk(HALF);
        bus.spi_cs_n = 1'b1;
        wait_clk(HALF);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input int ncmd, input int nbits);
        int pops0, cv0, flen, exp_pops, exp_cv;
        logic [31:0] word;
        logic [63:0] rx, exp_rx;
        logic [3:0] op, lvl;
        logic empty, busy_mid;
        pops0 = pop_cycles;
        cv0 = cv_cycles;
        op = cmd[7:4];
        empty = (wr_ptr == rd_ptr);
        lvl = 4'(wr_ptr - rd_ptr);
        word = '0;
        flen = 0;
        exp_pops = 0;
        exp_cv = 0;
        if (ncmd == 8) begin
            exp_cv = 1;
            m_cmd = op;
            if (op == 4'h1) begin
                word[23:0] = empty ? 24'h000000 : mem[rd_ptr % 16];
                if (FRAME == 32) word[31:24] = {empty, m_uf, 2'b00, lvl};
                flen = FRAME;
                exp_pops = empty ? 0 : 1;
                if (empty) m_uf = 1'b1;
            end else if (op == 4'h2) begin
                word[7:0] = {empty, m_uf, 2'b00, lvl};
                flen = 8;
                if (nbits >= 8) m_uf = 1'b0;
            end
        end
        exp_rx = '0;
        for (int j = 0; j < nbits; j++)
            exp_rx = {exp_rx[62:0], (j < flen) ? word[flen-1-j] : 1'b0};

        spi_frame(cmd, ncmd, nbits, rx, busy_mid);
        $display("xfer cmd=%02h ncmd=%0d nbits=%0d rx=%0h expect=%0h", cmd, ncmd, nbits, rx, exp_rx);
        check("rx_bits", rx, exp_rx);
        check("pop_count", 64'(pop_cycles - pops0), 64'(exp_pops));
        check("cmd_valid_count", 64'(cv_cycles - cv0), 64'(exp_cv));
        check("spi_cmd", 64'(bus.spi_cmd), 64'(m_cmd));
        check("busy_mid", 64'(busy_mid), 64'd1);
        check("busy_idle", 64'(bus.busy), 64'd0);
        check("miso_idle", 64'(bus.spi_miso), 64'd0);
    endtask

    initial begin
        logic s;
        int ncmd, nbits, pick, pops0, cv0;
        logic [7:0] cmd;

        bus.spi_cs_n = 1'b1;
        bus.spi_sclk = 1'b0;
        bus.spi_mosi = 1'b0;
        wait_clk(4);
        check("rst_miso", 64'(bus.spi_miso), 64'd0);
        check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
        check("rst_spi_cmd", 64'(bus.spi_cmd), 64'd0);
        check("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        reset = 1'b0;
        wait_clk(10);

        // Single word read.
        push(24'hA5C3F0);
        run_frame(8'h10, 8, FRAME);
        // Empty read, then level reads showing and clearing underflow.
        run_frame(8'h10, 8, FRAME);
        run_frame(8'h20, 8, 8);
        run_frame(8'h20, 8, 8);
        // Level with five words.
        for (int i = 0; i < 5; i++) push(24'($urandom));
        run_frame(8'h20, 8, 8);
        // Abort after 12 data bits, then the next word.
        run_frame(8'h10, 8, 12);
        run_frame(8'h10, 8, FRAME);
        // Unknown opcode, then overlong READ_COUNT.
        run_frame(8'h70, 8, 16);
        run_frame(8'h10, 8, 40);
        // Partial command byte.
        run_frame(8'h10, 5, 0);
        // Drain, then level 3 with 000123 at the head.
        for (int k = 0; k < 10 && wr_ptr != rd_ptr; k++) run_frame(8'h10, 8, FRAME);
        push(24'h000123);
        push(24'($urandom));
        push(24'($urandom));
        run_frame(8'h10, 8, FRAME);

        // Randomised frames.
        for (int n = 0; n < 16; n++) begin
            if (wr_ptr - rd_ptr < 8 && $urandom_range(0, 1) == 1) push(24'($urandom));
            pick = int'($urandom_range(0, 3));
            cmd[3:0] = 4'($urandom);
            cmd[7:4] = (pick < 2) ? 4'h1 : (pick == 2) ? 4'h2 : 4'($urandom);
            ncmd = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 7)) : 8;
            nbits = (ncmd == 8) ? int'($urandom_range(0, 40)) : 0;
            run_frame(cmd, ncmd, nbits);
        end

        // Reset mid-command while cs_n stays low: no frame may start until cs_n cycles.
        push(24'h5A5A5A);
        bus.spi_cs_n = 1'b0;
        wait_clk(HALF);
        for (int i = 0; i < 4; i++) sclk_bit(1'b0, s);
        reset = 1'b1;
        #1;
        check("async_rst_busy", 64'(bus.busy), 64'd0);
        check("async_rst_spi_cmd", 64'(bus.spi_cmd), 64'd0);
        m_uf = 1'b0;
        m_cmd = 4'h0;
        wait_clk(3);
        reset = 1'b0;
        pops0 = pop_cycles;
        cv0 = cv_cycles;
        wait_clk(HALF);
        for (int i = 0; i < 16; i++) sclk_bit((i == 3) ? 1'b1 : 1'b0, s);
        check("post_rst_no_pop", 64'(pop_cycles - pops0), 64'd0);
        check("post_rst_no_cmd", 64'(cv_cycles - cv0), 64'd0);
        check("post_rst_miso", 64'(bus.spi_miso), 64'd0);
        bus.spi_cs_n = 1'b1;
        wait_clk(HALF);
        run_frame(8'h20, 8, 8);
        run_frame(8'h10, 8, FRAME);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
